// File: rtl/tube_pkg.sv
// Shared constants for the Minisys seven-segment tube driver:
// register offsets, reset values and the hex font.
package tube_pkg;

  typedef enum logic [1:0] {
    TUBE_OFF_VALUE = 2'd0,
    TUBE_OFF_CTRL  = 2'd1,
    TUBE_OFF_RSVD2 = 2'd2,
    TUBE_OFF_RSVD3 = 2'd3
  } tubeOffset_t;

  localparam logic [15:0] TUBE_CTRL_RESET = 16'h00FF;
  localparam logic [7:0]  TUBE_SEG_OFF    = 8'hFF;

  // Active-high {g,f,e,d,c,b,a}; entry 0 sits in the least significant slot.
  localparam logic [15:0][6:0] TUBE_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/tube_hex_decoder.sv
// Combinational hex nibble to active-high seven-segment glyph.
module tube_hex_decoder
  import tube_pkg::*;
(
  input  logic [3:0] iNibble,
  output logic [6:0] oSegments
);

  always_comb begin
    oSegments = TUBE_FONT[iNibble];
  end

endmodule

// File: rtl/tube_scan_driver.sv
// Eight-digit multiplexed tube driver: VALUE/CTRL registers written by the
// controller strobe, prescaled digit scan, registered active-low pins.
module tube_scan_driver
  import tube_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 23000,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iTubeWrite,
  input  logic [1:0]  iAddressOffset,
  input  logic [31:0] iWriteData,
  output logic [7:0]  oTubeSegments,
  output logic [7:0]  oTubeSelect
);

  localparam int unsigned     PW          = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]   LAST_COUNT  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]   BLANK_COUNT = PW'(BLANK_CYCLES);

  logic [31:0]   valueReg;
  logic [15:0]   ctrlReg;
  logic [PW-1:0] prescaler;
  logic [2:0]    digitIndex;
  logic [7:0]    enableMask;
  logic [7:0]    dpMask;
  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic          lit;

  always_comb begin
    enableMask = ctrlReg[7:0];
    dpMask     = ctrlReg[15:8];
    nibble     = valueReg[{digitIndex, 2'b00} +: 4];
    lit        = (prescaler >= BLANK_COUNT) && enableMask[digitIndex];
  end

  tube_hex_decoder uDecoder (
    .iNibble   (nibble),
    .oSegments (glyph)
  );

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      valueReg <= '0;
      ctrlReg  <= TUBE_CTRL_RESET;
    end else if (iTubeWrite) begin
      case (tubeOffset_t'(iAddressOffset))
        TUBE_OFF_VALUE: valueReg <= iWriteData;
        TUBE_OFF_CTRL:  ctrlReg  <= iWriteData[15:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      prescaler  <= '0;
      digitIndex <= '0;
    end else if (prescaler == LAST_COUNT) begin
      prescaler  <= '0;
      digitIndex <= digitIndex + 3'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Pins are a pure function of the pre-edge scan state and registers,
  // so a write landing on a slot change is already loaded by the first lit cycle.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      oTubeSelect   <= '1;
      oTubeSegments <= TUBE_SEG_OFF;
    end else if (!lit) begin
      oTubeSelect   <= '1;
      oTubeSegments <= TUBE_SEG_OFF;
    end else begin
      oTubeSelect   <= ~(8'b0000_0001 << digitIndex);
      oTubeSegments <= ~{dpMask[digitIndex], glyph};
    end
  end

endmodule
